// File: rtl/inv_lift_row_seq.sv
// Inverse 5/3 (LeGall) lifting sequencer for one line of the DWT.
// Pass U rebuilds the even samples in place from low-pass/high-pass pairs,
// pass P then rebuilds the odd samples from the high-pass and rebuilt evens.
// Both RAMs are single-port with a one-cycle synchronous read.
module inv_lift_row_seq #(
    parameter int unsigned W  = 26,
    parameter int unsigned AW = 7,
    parameter int unsigned N  = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] even_addr,
    input  logic [W-1:0]  even_dout,
    output logic [W-1:0]  even_din,
    output logic          even_we,
    output logic [AW-1:0] odd_addr,
    input  logic [W-1:0]  odd_dout,
    output logic [W-1:0]  odd_din,
    output logic          odd_we
);

    localparam int unsigned XW   = W + 2;
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    typedef enum logic [3:0] {
        IDLE, U_ADDR, U_WAIT, U_WR, P_PRE, P_PREW, P_ADDR, P_WAIT, P_WR, DONE
    } state_t;

    state_t        state, state_n;
    logic [AW-1:0] idx, idx_n;
    logic [W-1:0]  hprev, hprev_n;
    logic [W-1:0]  hcur, hcur_n;
    logic [W-1:0]  ecur, ecur_n;
    logic [W-1:0]  enext, enext_n;
    logic          busy_n, done_n, even_we_n, odd_we_n;
    logic [AW-1:0] even_addr_n, odd_addr_n;
    logic [W-1:0]  even_din_n, odd_din_n;

    // Sign extension into the guard-bit arithmetic width.
    function automatic logic signed [XW-1:0] sx(input logic [W-1:0] v);
        return {{2{v[W-1]}}, v};
    endfunction

    // Next even address in pass P: one ahead, mirrored at the right edge.
    function automatic logic [AW-1:0] clip_next(input logic [AW-1:0] k);
        logic [AW:0] k1;
        k1 = {1'b0, k} + (AW+1)'(1);
        if (k1 > {1'b0, LAST}) return LAST;
        return k1[AW-1:0];
    endfunction

    // Lifting arithmetic; h[-1] mirrors h[0] on the first pair.
    logic [W-1:0]         h_left;
    logic signed [XW-1:0] u_sum, p_sum;
    logic [W-1:0]         u_res, p_res;

    assign h_left = (idx == '0) ? odd_dout : hprev;
    assign u_sum  = sx(h_left) + sx(odd_dout) + XW'(2);
    assign u_res  = W'(sx(even_dout) - (u_sum >>> 2));
    assign p_sum  = sx(ecur) + sx(even_dout);
    assign p_res  = W'(sx(odd_dout) + (p_sum >>> 1));

    // State, index, hold registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            hprev     <= '0;
            hcur      <= '0;
            ecur      <= '0;
            enext     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            even_addr <= '0;
            odd_addr  <= '0;
            even_din  <= '0;
            odd_din   <= '0;
            even_we   <= 1'b0;
            odd_we    <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            hprev     <= hprev_n;
            hcur      <= hcur_n;
            ecur      <= ecur_n;
            enext     <= enext_n;
            busy      <= busy_n;
            done      <= done_n;
            even_addr <= even_addr_n;
            odd_addr  <= odd_addr_n;
            even_din  <= even_din_n;
            odd_din   <= odd_din_n;
            even_we   <= even_we_n;
            odd_we    <= odd_we_n;
        end
    end

    // Next state; outputs are prepared for the state being entered.
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        hprev_n     = hprev;
        hcur_n      = hcur;
        ecur_n      = ecur;
        enext_n     = enext;
        even_addr_n = even_addr;
        odd_addr_n  = odd_addr;
        even_din_n  = even_din;
        odd_din_n   = odd_din;
        even_we_n   = 1'b0;
        odd_we_n    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n     = U_ADDR;
                    idx_n       = '0;
                    even_addr_n = '0;
                    odd_addr_n  = '0;
                end
            end
            U_ADDR: state_n = U_WAIT;
            U_WAIT: begin
                hcur_n     = odd_dout;
                even_din_n = u_res;
                even_we_n  = 1'b1;
                state_n    = U_WR;
            end
            U_WR: begin
                hprev_n = hcur;
                if (idx == LAST) begin
                    idx_n       = '0;
                    even_addr_n = '0;
                    state_n     = P_PRE;
                end else begin
                    idx_n       = idx + AW'(1);
                    even_addr_n = idx + AW'(1);
                    odd_addr_n  = idx + AW'(1);
                    state_n     = U_ADDR;
                end
            end
            P_PRE: state_n = P_PREW;
            P_PREW: begin
                ecur_n      = even_dout;
                even_addr_n = clip_next(idx);
                odd_addr_n  = idx;
                state_n     = P_ADDR;
            end
            P_ADDR: state_n = P_WAIT;
            P_WAIT: begin
                enext_n   = even_dout;
                odd_din_n = p_res;
                odd_we_n  = 1'b1;
                state_n   = P_WR;
            end
            P_WR: begin
                ecur_n = enext;
                if (idx == LAST) begin
                    state_n = DONE;
                end else begin
                    idx_n       = idx + AW'(1);
                    even_addr_n = clip_next(idx + AW'(1));
                    odd_addr_n  = idx + AW'(1);
                    state_n     = P_ADDR;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
        done_n = (state_n == DONE);
    end

endmodule

// File: tb/tb_inv_lift_row_seq.sv
// Directed bench for inv_lift_row_seq with behavioural sync-read RAMs.
module tb_inv_lift_row_seq;

    localparam int W     = 26;
    localparam int AW    = 7;
    localparam int N     = 64;
    localparam int DEPTH = 1 << AW;
    localparam int LAT   = 6 * N + 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy, done;
    logic [AW-1:0] even_addr, odd_addr;
    logic [W-1:0]  even_dout, odd_dout;
    logic [W-1:0]  even_din, odd_din;
    logic          even_we, odd_we;

    inv_lift_row_seq #(.W(W), .AW(AW), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .even_addr (even_addr),
        .even_dout (even_dout),
        .even_din  (even_din),
        .even_we   (even_we),
        .odd_addr  (odd_addr),
        .odd_dout  (odd_dout),
        .odd_din   (odd_din),
        .odd_we    (odd_we)
    );

    always #5 clk = ~clk;

    // RAM models with a bench-side load port
    logic [W-1:0]  even_mem [DEPTH];
    logic [W-1:0]  odd_mem  [DEPTH];
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [W-1:0]  ld_e, ld_o;

    always @(posedge clk) begin
        even_dout <= even_mem[even_addr];
        odd_dout  <= odd_mem[odd_addr];
        if (ld_we) begin
            even_mem[ld_addr] <= ld_e;
            odd_mem[ld_addr]  <= ld_o;
        end else begin
            if (even_we) even_mem[even_addr] <= even_din;
            if (odd_we)  odd_mem[odd_addr]   <= odd_din;
        end
    end

    // Write/done activity monitor
    logic mon_clr;
    int   ew_cnt, ow_cnt, done_cnt;
    logic both_seen, oob_seen, x_seen;

    always @(posedge clk) begin
        if (mon_clr) begin
            ew_cnt    <= 0;
            ow_cnt    <= 0;
            done_cnt  <= 0;
            both_seen <= 1'b0;
            oob_seen  <= 1'b0;
            x_seen    <= 1'b0;
        end else begin
            if (even_we) ew_cnt <= ew_cnt + 1;
            if (odd_we)  ow_cnt <= ow_cnt + 1;
            if (done)    done_cnt <= done_cnt + 1;
            if (even_we && odd_we) both_seen <= 1'b1;
            if ((even_we && int'(even_addr) >= N) || (odd_we && int'(odd_addr) >= N))
                oob_seen <= 1'b1;
            if ((even_we && $isunknown(even_din)) || (odd_we && $isunknown(odd_din)))
                x_seen <= 1'b1;
        end
    end

    int n_tot = 0;
    int n_bad = 0;

    logic [W-1:0] src_e [N];
    logic [W-1:0] src_o [N];
    logic [W-1:0] exp_e [N];
    logic [W-1:0] exp_o [N];

    typedef struct {
        logic [W-1:0] ev;
        logic [W-1:0] od;
        logic [W-1:0] xe;
        logic [W-1:0] xo;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string nm, input int act, input int want);
        n_tot++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, want);
        end
    endtask

    task automatic load_ram();
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            ld_we   = 1'b1;
            ld_addr = AW'(i);
            ld_e    = src_e[i];
            ld_o    = src_o[i];
        end
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    task automatic clear_mon();
        @(negedge clk) mon_clr = 1'b1;
        @(negedge clk) mon_clr = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts edges from the start-sampling edge (counted as 1) to done high.
    task automatic wait_done(input int pulse_at, output int lat);
        int n;
        n   = 0;
        lat = -1;
        while (n < LAT + 50) begin
            @(posedge clk);
            #1;
            n++;
            start = (n == pulse_at);
            if (done) begin
                lat = n + 1;
                break;
            end
        end
    endtask

    task automatic check_ram(input string tag);
        int bad_e, bad_o, fe, fo;
        bad_e = 0; bad_o = 0; fe = 0; fo = 0;
        for (int i = 0; i < N; i++) begin
            if (even_mem[i] !== exp_e[i]) begin
                if (bad_e == 0) fe = i;
                bad_e++;
            end
            if (odd_mem[i] !== exp_o[i]) begin
                if (bad_o == 0) fo = i;
                bad_o++;
            end
        end
        n_tot++;
        if (bad_e != 0) begin
            n_bad++;
            $display("FAIL %s even_ram: %0d wrong, first [%0d] got %0d want %0d",
                     tag, bad_e, fe, $signed(even_mem[fe]), $signed(exp_e[fe]));
        end
        n_tot++;
        if (bad_o != 0) begin
            n_bad++;
            $display("FAIL %s odd_ram: %0d wrong, first [%0d] got %0d want %0d",
                     tag, bad_o, fo, $signed(odd_mem[fo]), $signed(exp_o[fo]));
        end
    endtask

    task automatic run_line(input string tag);
        int lat;
        clear_mon();
        do_start();
        wait_done(-1, lat);
        chk({tag, " latency"}, lat, LAT);
        @(posedge clk);
        #1;
        chk({tag, " busy_after"}, int'(busy), 0);
        chk({tag, " even_writes"}, ew_cnt, N);
        chk({tag, " odd_writes"}, ow_cnt, N);
        chk({tag, " done_pulses"}, done_cnt, 1);
        chk({tag, " we_overlap_or_oob_or_x"}, int'(both_seen | oob_seen | x_seen), 0);
        check_ram(tag);
    endtask

    // Straight evaluation of the inverse lifting equations in 64-bit math.
    task automatic inv_model();
        longint l, h, hp, e0, e1;
        longint ev [N];
        for (int i = 0; i < N; i++) begin
            l  = longint'($signed(src_e[i]));
            h  = longint'($signed(src_o[i]));
            hp = (i == 0) ? h : longint'($signed(src_o[i-1]));
            exp_e[i] = W'(l - ((hp + h + 2) >>> 2));
            ev[i]    = longint'($signed(exp_e[i]));
        end
        for (int i = 0; i < N; i++) begin
            h  = longint'($signed(src_o[i]));
            e0 = ev[i];
            e1 = (i == N - 1) ? ev[N-1] : ev[i+1];
            exp_o[i] = W'(h + ((e0 + e1) >>> 1));
        end
    endtask

    initial begin
        longint x  [2*N];
        longint hf [N];
        longint hp, er;
        int     lat, n;
        bit     found;

        rst = 1'b1; start = 1'b0; ld_we = 1'b0; ld_addr = '0;
        ld_e = '0; ld_o = '0; mon_clr = 1'b1;

        vecs[0] = '{W'(100),      W'(0),         W'(100),       W'(100)};
        vecs[1] = '{W'(0),        W'(-3),        W'(1),         W'(-2)};
        vecs[2] = '{W'(33554431), W'(-33554432), W'(-16777217), W'(16777215)};
        vecs[3] = '{W'(-7),       W'(5),         W'(-10),       W'(-5)};

        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset we", int'({even_we, odd_we}), 0);
        chk("reset addr", int'({even_addr, odd_addr}), 0);
        chk("reset even_din", int'(even_din), 0);
        chk("reset odd_din", int'(odd_din), 0);
        @(negedge clk);
        rst = 1'b0;
        mon_clr = 1'b0;

        // Constant-fill table
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < N; i++) begin
                src_e[i] = vecs[v].ev; src_o[i] = vecs[v].od;
                exp_e[i] = vecs[v].xe; exp_o[i] = vecs[v].xo;
            end
            load_ram();
            run_line($sformatf("vec%0d", v));
        end

        // Ramp through a forward 5/3 transform must come back bit-exact
        for (int k = 0; k < 2 * N; k++) x[k] = longint'(k);
        for (int i = 0; i < N; i++) begin
            er    = (i == N - 1) ? x[2*N-2] : x[2*i+2];
            hf[i] = x[2*i+1] - ((x[2*i] + er) >>> 1);
        end
        for (int i = 0; i < N; i++) begin
            hp       = (i == 0) ? hf[0] : hf[i-1];
            src_e[i] = W'(x[2*i] + ((hp + hf[i] + 2) >>> 2));
            src_o[i] = W'(hf[i]);
            exp_e[i] = W'(x[2*i]);
            exp_o[i] = W'(x[2*i+1]);
        end
        load_ram();
        run_line("ramp");

        // Pseudo-random full-range data against the equation model
        for (int i = 0; i < N; i++) begin
            src_e[i] = W'($urandom);
            src_o[i] = W'($urandom);
        end
        inv_model();
        load_ram();
        run_line("random");

        // Start re-pulsed mid-run and in the DONE cycle: both ignored
        for (int i = 0; i < N; i++) begin
            src_e[i] = vecs[0].ev; src_o[i] = vecs[0].od;
            exp_e[i] = vecs[0].xe; exp_o[i] = vecs[0].xo;
        end
        load_ram();
        clear_mon();
        do_start();
        wait_done(4, lat);
        chk("repulse latency", lat, LAT);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("repulse done_pulses", done_cnt, 1);
        chk("repulse total_writes", ew_cnt + ow_cnt, 2 * N);
        chk("repulse busy", int'(busy), 0);
        check_ram("repulse");

        // Reset during pass U at i=10, then a clean rerun
        for (int i = 0; i < N; i++) begin
            src_e[i] = vecs[3].ev; src_o[i] = vecs[3].od;
            exp_e[i] = vecs[3].xe; exp_o[i] = vecs[3].xo;
        end
        load_ram();
        clear_mon();
        do_start();
        found = 1'b0;
        n = 0;
        while (!found && n < LAT) begin
            @(posedge clk);
            #1;
            n++;
            if (even_we && even_addr == AW'(10)) found = 1'b1;
        end
        chk("rst reached_i10", int'(found), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst busy", int'(busy), 0);
        chk("rst we", int'({even_we, odd_we}), 0);
        rst = 1'b0;
        clear_mon();
        repeat (10) @(posedge clk);
        #1;
        chk("rst idle_writes", ew_cnt + ow_cnt, 0);
        load_ram();
        run_line("after_rst");

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
